// File: rtl/ft_tx_drain_if.sv
// FIFO read port plus FT2232H sync-245 write pads, grouped for the tx drain.
interface ft_tx_drain_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       ft_txe_n;
    logic       ft_wr_n;
    logic [7:0] ft_data;
    logic       ft_siwu_n;

    // master: the drain itself; slave: the FIFO and FT chip side
    modport master (
        input  fifo_empty, fifo_data, ft_txe_n,
        output fifo_rd_en, ft_wr_n, ft_data, ft_siwu_n
    );
    modport slave (
        output fifo_empty, fifo_data, ft_txe_n,
        input  fifo_rd_en, ft_wr_n, ft_data, ft_siwu_n
    );
endinterface

// File: rtl/ft_tx_drain.sv
// Pops the FPGA-to-host byte FIFO and drives FT2232H TXE#/WR#/DATA through an out+skid pipeline.
// Optional send-immediate pulse on SIWU# after an idle period: define FT_TX_SIWU_EN.
module ft_tx_drain #(
    parameter int CNT_WIDTH  = 32,
    parameter int IDLE_FLUSH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ft_tx_drain_if.master        bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] byte_count
);

    logic       out_valid, skid_valid, inflight;
    logic [7:0] out_reg, skid_reg;
    logic       out_valid_n, skid_valid_n;
    logic [7:0] out_reg_n, skid_reg_n;
    logic       accept, rd_en;
    logic [1:0] occ, occ_left;

    assign accept   = out_valid && !bus.ft_txe_n;
    assign occ      = 2'(out_valid) + 2'(skid_valid) + 2'(inflight);
    assign occ_left = occ - 2'(accept);
    // Combinational pop so a slot freed by an accept is refilled without a bubble.
    assign rd_en    = !reset && !bus.fifo_empty && (occ_left < 2'd2);

    assign bus.fifo_rd_en = rd_en;
    assign bus.ft_wr_n    = !out_valid;
    assign bus.ft_data    = out_reg;
    assign busy           = out_valid || skid_valid || inflight;

    always_comb begin
        out_valid_n  = out_valid;
        skid_valid_n = skid_valid;
        out_reg_n    = out_reg;
        skid_reg_n   = skid_reg;
        if (accept) begin
            if (skid_valid) begin
                out_reg_n    = skid_reg;
                skid_valid_n = 1'b0;
            end else begin
                out_valid_n  = 1'b0;
            end
        end
        // A landing byte takes the output slot only if nothing older remains ahead of it.
        if (inflight) begin
            if (!out_valid_n) begin
                out_valid_n  = 1'b1;
                out_reg_n    = bus.fifo_data;
            end else begin
                skid_valid_n = 1'b1;
                skid_reg_n   = bus.fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            inflight   <= 1'b0;
            out_reg    <= '0;
            skid_reg   <= '0;
            byte_count <= '0;
        end else begin
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            inflight   <= rd_en;
            out_reg    <= out_reg_n;
            skid_reg   <= skid_reg_n;
            if (accept) byte_count <= byte_count + 1'b1;
        end
    end

`ifdef FT_TX_SIWU_EN
    localparam int IW = $clog2(IDLE_FLUSH + 1);

    logic [IW-1:0] idle_cnt;
    logic          armed;
    logic          siwu_n;

    assign bus.ft_siwu_n = siwu_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
            armed    <= 1'b0;
            siwu_n   <= 1'b1;
        end else begin
            siwu_n <= 1'b1;
            if (accept) begin
                armed    <= 1'b1;
                idle_cnt <= '0;
            end else if (!bus.fifo_empty) begin
                idle_cnt <= '0;
            end else if (!busy && armed) begin
                if (idle_cnt == IW'(IDLE_FLUSH - 1)) begin
                    siwu_n   <= 1'b0;
                    idle_cnt <= '0;
                    armed    <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg    = (IDLE_FLUSH > 0);
    assign bus.ft_siwu_n = 1'b1;
`endif

endmodule

// File: tb/tb_ft_tx_drain.sv
// Directed bench for ft_tx_drain: queue-based pipeline model checked every cycle, plus literal pins.
module tb_ft_tx_drain;
    logic        clk;
    logic        reset;
    logic        busy;
    logic [31:0] byte_count;

    ft_tx_drain_if bus();

    ft_tx_drain #(.CNT_WIDTH(32), .IDLE_FLUSH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // environment FIFO (registered read data)
    logic [7:0] env_q[$];
    logic [7:0] pend;
    logic       pend_v = 1'b0;

    // model: bytes not yet popped, bytes popped but not yet accepted
    logic [7:0] m_fifo[$];
    logic [7:0] m_pipe[$];
    logic       m_infl = 1'b0;
    logic [31:0] m_cnt = '0;

    // observations of the DUT for literal checks
    logic [7:0] dut_log[$];
    logic [7:0] exp_q[$];
    int n_pops, n_wr_low, first_acc, last_acc, first_pop, last_pop;
    logic last_rd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(logic [7:0] b);
        env_q.push_back(b);
        m_fifo.push_back(b);
    endtask

    task automatic clear_obs();
        dut_log.delete();
        n_pops = 0; n_wr_low = 0;
        first_acc = -1; last_acc = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic step(logic txe, logic rst);
        int   landed;
        logic acc_e, rd_e;
        @(negedge clk);
        bus.ft_txe_n = txe;
        reset        = rst;
        if (pend_v) begin
            bus.fifo_data = pend;
            pend_v = 1'b0;
        end
        bus.fifo_empty = (env_q.size() == 0);
        #1;
        landed = m_pipe.size() - (m_infl ? 1 : 0);
        acc_e  = !rst && (landed > 0) && !txe;
        rd_e   = !rst && (m_fifo.size() > 0) && ((m_pipe.size() - (acc_e ? 1 : 0)) < 2);

        chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(rd_e));
        chk("ft_wr_n",    32'(bus.ft_wr_n),    32'(!(landed > 0)));
        chk("busy",       32'(busy),           32'(m_pipe.size() > 0));
        chk("byte_count", byte_count,          m_cnt);
        if (landed > 0) chk("ft_data", 32'(bus.ft_data), 32'(m_pipe[0]));
`ifndef FT_TX_SIWU_EN
        chk("ft_siwu_n", 32'(bus.ft_siwu_n), 32'd1);
`endif

        last_rd = bus.fifo_rd_en;
        if (!rst && !bus.ft_wr_n && !txe) begin
            dut_log.push_back(bus.ft_data);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (bus.fifo_rd_en) begin
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (!bus.ft_wr_n) n_wr_low++;
        if (bus.fifo_rd_en && env_q.size() > 0) begin
            pend   = env_q.pop_front();
            pend_v = 1'b1;
        end

        if (rst) begin
            m_pipe.delete();
            m_infl = 1'b0;
            m_cnt  = '0;
        end else begin
            if (acc_e) begin
                void'(m_pipe.pop_front());
                m_cnt++;
            end
            m_infl = 1'b0;
            if (rd_e) begin
                m_pipe.push_back(m_fifo.pop_front());
                m_infl = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        clear_obs();
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((m_pipe.size() > 0 || m_fifo.size() > 0) && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 200) begin
            n_vec++; n_bad++;
            $display("FAIL %s: drain timeout, pipe=%0d fifo=%0d", name, m_pipe.size(), m_fifo.size());
        end
        step(1'b0, 1'b0);
    endtask

    task automatic chk_log(string name);
        chk({name, "_len"}, 32'(dut_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
            chk(name, 32'(dut_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        reset          = 1'b1;
        bus.ft_txe_n   = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        clear_obs();

        // reset state
        do_reset();
        chk("rst_wr_n",   32'(bus.ft_wr_n),  32'd1);
        chk("rst_data",   32'(bus.ft_data),  32'h0);
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_count",  byte_count,        32'd0);
        chk("rst_siwu_n", 32'(bus.ft_siwu_n), 32'd1);

        // three-byte burst
        push(8'h11); push(8'h22); push(8'h33);
        drain("t1");
        step(1'b0, 1'b0);
        chk("t1_pops",        32'(n_pops),             32'd3);
        chk("t1_pops_consec", 32'(last_pop - first_pop), 32'd2);
        chk("t1_wr_low",      32'(n_wr_low),           32'd3);
        chk("t1_count",       byte_count,              32'd3);
        chk("t1_busy",        32'(busy),               32'd0);
        exp_q = {8'h11, 8'h22, 8'h33};
        chk_log("t1_data");

        // stall under TXE# high, then release
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("t2_stall_pops", 32'(n_pops),       32'd2);
        chk("t2_held_data",  32'(bus.ft_data),  32'h00);
        chk("t2_held_wr_n",  32'(bus.ft_wr_n),  32'd0);
        drain("t2");
        chk("t2_gapfree", 32'(last_acc - first_acc), 32'd7);
        chk("t2_count",   byte_count,               32'd8);
        exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        chk_log("t2_data");

        // TXE# high every third cycle across 20 bytes
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            push(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        for (int i = 0; i < 100 && (m_pipe.size() > 0 || m_fifo.size() > 0); i++)
            step((i % 3) == 2, 1'b0);
        drain("t3");
        chk("t3_count", byte_count, 32'd20);
        chk_log("t3_data");

        // FIFO runs dry mid-burst, refilled later
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(i));
        drain("t4a");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("t4_gap_wr_n", 32'(bus.ft_wr_n), 32'd1);
        push(8'h06);
        drain("t4b");
        chk("t4_count", byte_count, 32'd7);
        exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        chk_log("t4_data");

        // reset with two bytes held under TXE# high; FIFO is not rewound
        do_reset();
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("t5_held_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b1);
        chk("t5_no_pop_in_reset", 32'(last_rd), 32'd0);
        step(1'b1, 1'b0);
        chk("t5_wr_n",  32'(bus.ft_wr_n), 32'd1);
        chk("t5_busy",  32'(busy),        32'd0);
        chk("t5_count", byte_count,       32'd0);
        clear_obs();
        drain("t5");
        chk("t5_post_count", byte_count, 32'd2);
        exp_q = {8'hA2, 8'hA3};
        chk_log("t5_data");

        // long idle: SIWU# stays high in the default build (checked every cycle)
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
